// File: rtl/pp_ram_rd_arb_if.sv
// Bundle of the shared RAM read port signals between the path-parser read
// controllers and the read arbiter. The arbiter side is the slave modport.
interface pp_ram_rd_arb_if #(
    parameter int NUM_REQ         = 4,
    parameter int PATH_CHUNK_ADDR = 8,
    parameter int DATA_PATH       = 32
);
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0]                 req_lock;
    logic [NUM_REQ*PATH_CHUNK_ADDR-1:0] req_addr;
    logic [NUM_REQ-1:0]                 gnt;
    logic                               ram_rd;
    logic [PATH_CHUNK_ADDR-1:0]         ram_raddr;
    logic [DATA_PATH-1:0]               ram_rdata;
    logic [DATA_PATH-1:0]               rdata;
    logic [NUM_REQ-1:0]                 rdata_valid;
    logic                               busy;

    modport master (
        output req, req_lock, req_addr, ram_rdata,
        input  gnt, ram_rd, ram_raddr, rdata, rdata_valid, busy
    );

    modport slave (
        input  req, req_lock, req_addr, ram_rdata,
        output gnt, ram_rd, ram_raddr, rdata, rdata_valid, busy
    );
endinterface

// File: rtl/pp_ram_rd_arb.sv
// Round-robin read arbiter for a single RAM read port shared by several
// path-parser read controllers. A requester may lock the port for up to
// MAX_LOCK consecutive grants. Read data comes back two cycles after the
// grant and is tagged one-hot to the requester that asked for it.
module pp_ram_rd_arb #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_LOCK        = 4,
    parameter int PATH_CHUNK_ADDR = 8,
    parameter int DATA_PATH       = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    pp_ram_rd_arb_if.slave         bus
);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(MAX_LOCK) + 1;
    localparam bit LOCK_EN = (MAX_LOCK > 1);

    typedef enum logic [0:0] {UNLOCKED, LOCKED} lockState_t;

    lockState_t                 r_state;
    lockState_t                 w_stateNext;
    logic [IDX_W-1:0]           r_rrPtr;
    logic [IDX_W-1:0]           w_rrNext;
    logic [IDX_W-1:0]           r_owner;
    logic [IDX_W-1:0]           w_ownerNext;
    logic [CNT_W-1:0]           r_lockCnt;
    logic [CNT_W-1:0]           w_cntNext;
    logic [CNT_W-1:0]           w_cntInc;
    logic [IDX_W-1:0]           w_base;
    logic                       w_found;
    logic [IDX_W-1:0]           w_grantIdx;
    logic [NUM_REQ-1:0]         w_gnt;
    logic [PATH_CHUNK_ADDR-1:0] w_selAddr;
    logic                       r_ramRd;
    logic [PATH_CHUNK_ADDR-1:0] r_ramRaddr;
    logic [NUM_REQ-1:0]         r_tag1;
    logic [NUM_REQ-1:0]         r_tag2;

    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] x);
        if (x == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    assign w_cntInc = r_lockCnt + 1'b1;
    // While locked the stored pointer sits on the owner, so a lock release
    // searches from the slot after the owner.
    assign w_base   = (r_state == LOCKED) ? nextIdx(r_owner) : r_rrPtr;

    // Round-robin search: first asserted request at or after the base, wrapping.
    always_comb begin
        logic [IDX_W-1:0] idx;
        w_found    = 1'b0;
        w_grantIdx = '0;
        idx        = w_base;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.req[idx]) begin
                w_found    = 1'b1;
                w_grantIdx = idx;
            end
            idx = nextIdx(idx);
        end
    end

    // Grant selection and lock FSM next-state: a present lock owner wins outright,
    // otherwise the round-robin winner is granted and may take the lock.
    always_comb begin
        w_gnt       = '0;
        w_stateNext = r_state;
        w_rrNext    = r_rrPtr;
        w_ownerNext = r_owner;
        w_cntNext   = r_lockCnt;
        if (r_state == LOCKED && bus.req[r_owner]) begin
            w_gnt[r_owner] = 1'b1;
            if (!bus.req_lock[r_owner] || (w_cntInc == CNT_W'(MAX_LOCK))) begin
                w_stateNext = UNLOCKED;
                w_cntNext   = '0;
                w_rrNext    = nextIdx(r_owner);
            end else begin
                w_cntNext   = w_cntInc;
            end
        end else begin
            if (r_state == LOCKED) begin
                w_stateNext = UNLOCKED;
                w_cntNext   = '0;
                w_rrNext    = nextIdx(r_owner);
            end
            if (w_found) begin
                w_gnt[w_grantIdx] = 1'b1;
                if (LOCK_EN && bus.req_lock[w_grantIdx]) begin
                    w_stateNext = LOCKED;
                    w_ownerNext = w_grantIdx;
                    w_cntNext   = CNT_W'(1);
                    w_rrNext    = w_grantIdx;
                end else begin
                    w_rrNext    = nextIdx(w_grantIdx);
                end
            end
        end
    end

    // Address of the granted requester (grant is one-hot, so OR-select).
    always_comb begin
        w_selAddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_selAddr = bus.req_addr[i*PATH_CHUNK_ADDR +: PATH_CHUNK_ADDR];
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= UNLOCKED;
            r_rrPtr   <= '0;
            r_owner   <= '0;
            r_lockCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_rrPtr   <= w_rrNext;
            r_owner   <= w_ownerNext;
            r_lockCnt <= w_cntNext;
        end
    end

    // RAM strobe/address register and the two-stage grant tag pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ramRd    <= 1'b0;
            r_ramRaddr <= '0;
            r_tag1     <= '0;
            r_tag2     <= '0;
        end else begin
            r_ramRd <= |w_gnt;
            if (|w_gnt) begin
                r_ramRaddr <= w_selAddr;
            end
            r_tag1 <= w_gnt;
            r_tag2 <= r_tag1;
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.ram_rd      = r_ramRd;
    assign bus.ram_raddr   = r_ramRaddr;
    assign bus.rdata       = bus.ram_rdata;
    assign bus.rdata_valid = r_tag2;
    assign bus.busy        = r_ramRd | (|r_tag1) | (|r_tag2);
endmodule

// File: tb/tb_pp_ram_rd_arb.sv
// Testbench for pp_ram_rd_arb: directed scenarios plus random traffic,
// all checked against a behavioural arbitration model.
module tb_pp_ram_rd_arb;
    localparam int NUM_REQ  = 4;
    localparam int MAX_LOCK = 4;
    localparam int AW       = 8;
    localparam int DW       = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    pp_ram_rd_arb_if #(.NUM_REQ(NUM_REQ), .PATH_CHUNK_ADDR(AW), .DATA_PATH(DW)) bus ();

    pp_ram_rd_arb #(
        .NUM_REQ(NUM_REQ), .MAX_LOCK(MAX_LOCK),
        .PATH_CHUNK_ADDR(AW), .DATA_PATH(DW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: pointer, lock flag, owner, consecutive lock grants.
    int               mRr;
    int               mOwner;
    int               mCnt;
    bit               mLocked;
    logic [AW-1:0]    expAddr;
    bit               expRd;
    logic [3:0]       expTag1;
    logic [3:0]       expTag2;
    int               grantCount;
    int               validCount;
    bit               countOn = 1'b0;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int modelPick(input logic [3:0] r);
        int base;
        if (mLocked && r[mOwner]) return mOwner;
        base = mLocked ? (mOwner + 1) % NUM_REQ : mRr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(base + k) % NUM_REQ]) return (base + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic modelUpdate(input logic [3:0] r, input logic [3:0] lk, input int g);
        if (mLocked && r[mOwner]) begin
            mCnt++;
            if (!lk[mOwner] || mCnt == MAX_LOCK) begin
                mLocked = 1'b0;
                mCnt    = 0;
                mRr     = (mOwner + 1) % NUM_REQ;
            end
        end else begin
            if (mLocked) begin
                mLocked = 1'b0;
                mCnt    = 0;
                mRr     = (mOwner + 1) % NUM_REQ;
            end
            if (g >= 0) begin
                if (lk[g] && MAX_LOCK > 1) begin
                    mLocked = 1'b1;
                    mOwner  = g;
                    mCnt    = 1;
                    mRr     = g;
                end else begin
                    mRr = (g + 1) % NUM_REQ;
                end
            end
        end
    endtask

    task automatic modelReset();
        mRr = 0; mOwner = 0; mCnt = 0; mLocked = 1'b0;
        expAddr = '0; expRd = 1'b0; expTag1 = '0; expTag2 = '0;
    endtask

    // One clock cycle: drive requests, check the combinational grant, then
    // check the registered outputs just after the clock edge.
    task automatic applyStimulus(input logic [3:0] reqV, input logic [3:0] lockV,
                                 input int addrBase, output logic [3:0] gotGnt);
        logic [AW-1:0] addrs [NUM_REQ];
        logic [DW-1:0] rd;
        logic [AW-1:0] nextAddr;
        logic [3:0]    expG;
        int            g;
        bus.req      = reqV;
        bus.req_lock = lockV;
        for (int i = 0; i < NUM_REQ; i++) begin
            addrs[i] = (addrBase >= 0) ? AW'(addrBase) : AW'($urandom);
            bus.req_addr[i*AW +: AW] = addrs[i];
        end
        rd = DW'($urandom);
        bus.ram_rdata = rd;
        #1;
        g    = modelPick(reqV);
        expG = (g >= 0) ? 4'(1 << g) : 4'b0000;
        checkOutput("gnt", 64'(bus.gnt), 64'(expG));
        checkOutput("rdata", 64'(bus.rdata), 64'(rd));
        gotGnt   = bus.gnt;
        nextAddr = (g >= 0) ? addrs[g] : expAddr;
        modelUpdate(reqV, lockV, g);
        @(posedge clk);
        #1;
        expTag2 = expTag1;
        expTag1 = expG;
        expRd   = (g >= 0);
        expAddr = nextAddr;
        if (countOn) begin
            grantCount += (g >= 0) ? 1 : 0;
            validCount += $countones(bus.rdata_valid);
        end
        checkOutput("ram_rd", 64'(bus.ram_rd), 64'(expRd));
        checkOutput("ram_raddr", 64'(bus.ram_raddr), 64'(expAddr));
        checkOutput("rdata_valid", 64'(bus.rdata_valid), 64'(expTag2));
        checkOutput("busy", 64'(bus.busy), 64'((|expTag1) | (|expTag2)));
    endtask

    task automatic runSeq(input string tag, input logic [3:0] reqV, input logic [3:0] lockV,
                          input logic [3:0] want);
        logic [3:0] got;
        applyStimulus(reqV, lockV, -1, got);
        checkOutput(tag, 64'(got), 64'(want));
    endtask

    task automatic idle(input int n);
        logic [3:0] got;
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 4'b0000, -1, got);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        bus.req = '0; bus.req_lock = '0; bus.req_addr = '0; bus.ram_rdata = '0;
        @(posedge clk);
        #1;
        checkOutput("rst_ram_rd", 64'(bus.ram_rd), 64'd0);
        checkOutput("rst_ram_raddr", 64'(bus.ram_raddr), 64'd0);
        checkOutput("rst_rdata_valid", 64'(bus.rdata_valid), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        modelReset();
    endtask

    logic [3:0] rrWant   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] lockWant [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};

    initial begin
        logic [3:0] got;
        modelReset();
        doReset();

        // All requesters held, no lock: plain rotation.
        for (int i = 0; i < 5; i++) runSeq("rr_rotate", 4'b1111, 4'b0000, rrWant[i]);
        idle(3);

        // Single requester streaming addresses 5..10 at full rate.
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0100, 4'b0000, 5 + k, got);
            checkOutput("stream_gnt", 64'(got), 64'(4'b0100));
        end
        idle(3);

        // Lock limited to MAX_LOCK grants, then the other requester gets one.
        doReset();
        for (int i = 0; i < 6; i++) runSeq("lock_max", 4'b0011, 4'b0001, lockWant[i]);
        idle(2);

        // Locked owner drops its request: the waiting requester wins immediately.
        doReset();
        runSeq("lock_take", 4'b0010, 4'b0010, 4'b0010);
        runSeq("lock_drop", 4'b1000, 4'b0000, 4'b1000);
        runSeq("after_drop", 4'b1111, 4'b0000, 4'b0001);
        idle(2);

        // A one-cycle pulse on another requester during a lock is never served.
        doReset();
        runSeq("pulse_a", 4'b0001, 4'b0001, 4'b0001);
        runSeq("pulse_b", 4'b0011, 4'b0001, 4'b0001);
        runSeq("pulse_c", 4'b0001, 4'b0001, 4'b0001);
        runSeq("pulse_d", 4'b0010, 4'b0000, 4'b0010);
        idle(3);

        // Reset pulsed right after a grant: in-flight read is discarded.
        doReset();
        runSeq("pre_rst", 4'b0100, 4'b0000, 4'b0100);
        rstn = 1'b0;
        bus.req = '0;
        #1;
        checkOutput("midrst_ram_rd", 64'(bus.ram_rd), 64'd0);
        checkOutput("midrst_valid", 64'(bus.rdata_valid), 64'd0);
        checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        modelReset();
        runSeq("post_rst", 4'b0010, 4'b0000, 4'b0010);
        idle(3);

        // Random traffic with a grant/valid scoreboard.
        doReset();
        grantCount = 0;
        validCount = 0;
        countOn    = 1'b1;
        for (int n = 0; n < 400; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)), -1, got);
        end
        idle(3);
        countOn = 1'b0;
        checkOutput("scoreboard", 64'(validCount), 64'(grantCount));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pp_ram_rd_arb.md
PP_RAM_RD_ARB -- requirements
Module: pp_ram_rd_arb

Interface
REQ-001 The block SHALL have these parameters: NUM_REQ, default 4, number of path-parser read controllers sharing the RAM read port; MAX_LOCK, default 4, the maximum number of consecutive locked grants.
REQ-002 The block SHALL have this port: clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have this port: rstn, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have this port: req, input, NUM_REQ, per-requester read request, held until granted.
REQ-005 The block SHALL have this port: req_lock, input, NUM_REQ, requester asks to keep the grant on its next request.
REQ-006 The block SHALL have this port: req_addr, input, NUM_REQ x PATH_CHUNK_ADDR width (flattened, requester i at slice i), read address.
REQ-007 The block SHALL have this port: gnt, output, NUM_REQ, one-hot combinational grant.
REQ-008 The block SHALL have this port: ram_rd, output, 1, registered RAM read strobe.
REQ-009 The block SHALL have this port: ram_raddr, output, PATH_CHUNK_ADDR width, registered RAM read address.
REQ-010 The block SHALL have this port: ram_rdata, input, DATA_PATH width, RAM read data, valid one cycle after ram_rd.
REQ-011 The block SHALL have this port: rdata, output, DATA_PATH width, ram_rdata broadcast to all requesters.
REQ-012 The block SHALL have this port: rdata_valid, output, NUM_REQ, one-hot, marks rdata for requester i.
REQ-013 The block SHALL have this port: busy, output, 1, a read is in flight (ram_rd or rdata pending).

Function
REQ-014 Arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo NUM_REQ; the first requester with req=1 is granted.
REQ-015 gnt SHALL be zero when no req is asserted; at most one gnt bit SHALL be set per cycle.
REQ-016 In a cycle where gnt[i]=1, the block SHALL register ram_rd=1 and ram_raddr=req_addr[i] for the next cycle (T+1).
REQ-017 In any cycle with no grant, ram_rd SHALL be 0 next cycle; ram_raddr SHALL hold its value.
REQ-018 rdata_valid[i] SHALL assert in cycle T+2 for a grant to i in cycle T, via a 2-stage registered grant-tag pipeline.
REQ-019 rdata SHALL equal ram_rdata combinationally.
REQ-020 Fixed latency, grant to rdata_valid, SHALL be 2 cycles; back-to-back grants SHALL be accepted every cycle, with full throughput of one read per cycle.
REQ-021 Without lock, rr_ptr SHALL update to (granted index + 1) mod NUM_REQ after each grant.
REQ-022 The lock FSM SHALL have two states, UNLOCKED and LOCKED, plus an owner register and a lock_cnt counter of width clog2(MAX_LOCK)+1.
REQ-023 UNLOCKED to LOCKED: a grant to i with req_lock[i]=1 SHALL set owner=i and lock_cnt=1; rr_ptr SHALL remain at owner.
REQ-024 In LOCKED, if req[owner]=1, owner SHALL win regardless of other requesters, and lock_cnt SHALL increment.
REQ-025 LOCKED to UNLOCKED SHALL occur on any of the following, after which rr_ptr=(owner+1) mod NUM_REQ:
- req_lock[owner]=0 at a grant;
- req[owner]=0 in a cycle;
- a grant that brings lock_cnt to MAX_LOCK.
REQ-026 In a cycle where LOCKED exits because req[owner]=0, normal round-robin SHALL grant the other requesters in that same cycle.
REQ-027 After a MAX_LOCK-forced exit, the former owner SHALL NOT be relocked before one grant to another requester, if any other requester is waiting.
REQ-028 A req dropped before being granted SHALL be legal and produce no RAM access.
REQ-029 busy SHALL be the OR of ram_rd and both tag-pipeline stages.

Reset
REQ-030 While rstn=0, regardless of clock:
- gnt-derived state cleared;
- ram_rd=0;
- ram_raddr=0;
- rdata_valid=0;
- busy=0;
- rr_ptr=0;
- FSM=UNLOCKED;
- owner=0;
- lock_cnt=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight tags; no rdata_valid SHALL assert for reads granted before reset.
REQ-032 The first cycle after rstn deassertion SHALL be able to grant.

Verification
REQ-033 Scenario: req=4'b1111 held, no lock -> gnt sequence 0001,0010,0100,1000,0001; ram_raddr follows each grant by 1 cycle; rdata_valid follows by 2 cycles.
REQ-034 Scenario: only req[2] held 6 cycles with addresses 5..10 -> 6 consecutive grants; ram_rd=1 for 6 cycles; rdata_valid[2] for 6 cycles starting T+2.
REQ-035 Scenario: req=4'b0011, req_lock[0]=1, MAX_LOCK=4 -> 4 grants to 0, then 1 grant to 1, then 0 again.
REQ-036 Scenario: LOCKED owner 1 drops req while req[3]=1 -> gnt[3] in the same cycle; FSM returns to UNLOCKED; rr_ptr=2 before the grant to 3.
REQ-037 Scenario: rstn pulsed low 1 cycle after a grant -> ram_rd=0 and rdata_valid=0 immediately, with no late valid; a grant is possible in the cycle after release.
REQ-038 Scenario: req[1] pulsed 1 cycle while req[0] is granted -> no grant to 1, no ram_rd for 1; a scoreboard checks that rdata_valid count equals grant count over random traffic.
